// File: rtl/wb_inst_responder_if.sv
// Wishbone bus between the core master and the instruction responder slave.
// Member names follow the slave's view of the bus.
interface wb_inst_responder_if #(
  parameter int WB_DW = 128
);
  logic [31:0]        i_wb_adr;
  logic [WB_DW/8-1:0] i_wb_sel;
  logic               i_wb_we;
  logic [WB_DW-1:0]   i_wb_dat;
  logic               i_wb_cyc;
  logic               i_wb_stb;
  logic [WB_DW-1:0]   o_wb_dat;
  logic               o_wb_ack;
  logic               o_wb_err;

  modport slave (
    input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack, o_wb_err
  );

  modport master (
    output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/wb_inst_responder.sv
// Wishbone slave feeding queued instruction words to a core fetch port and
// capturing stores; fixed ack latency with one-shot error injection.
module wb_inst_responder #(
  parameter int          WB_DW   = 128,
  parameter int          DEPTH   = 8,
  parameter int          ACK_LAT = 1,
  parameter logic [31:0] NOP     = 32'hF0801003
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_inst_valid,
  input  logic [31:0]              i_inst_data,
  output logic                     o_inst_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  input  logic                     i_err_inject,
  wb_inst_responder_if.slave       wb,
  output logic                     o_st_valid,
  output logic [31:0]              o_st_adr,
  output logic [WB_DW/8-1:0]       o_st_sel,
  output logic [WB_DW-1:0]         o_st_dat
);
  localparam int WB_SW  = WB_DW / 8;
  localparam int LANES  = WB_DW / 32;
  localparam int LW     = $clog2(DEPTH);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW     = (ACK_LAT > 2) ? $clog2(ACK_LAT - 1) : 1;
  localparam logic [LW:0]   FULL_LVL = (LW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'((ACK_LAT > 1) ? (ACK_LAT - 2) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r;
  logic [31:0]        adr_r;
  logic [WB_SW-1:0]   sel_r;
  logic [WB_DW-1:0]   dat_r;
  logic               we_r, err_r;

  logic [31:0]        mem_r [DEPTH];
  logic [LW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [LW:0]        level_r, level_nxt_s;
  logic               ready_r;

  logic [WB_DW-1:0]   rd_dat_r;
  logic               ack_r, berr_r, st_valid_r;
  logic [31:0]        st_adr_r;
  logic [WB_SW-1:0]   st_sel_r;
  logic [WB_DW-1:0]   st_dat_r;

  logic               req_s, enter_resp_s, push_s, pop_s, empty_s;
  logic               cur_we_s, cur_err_s;
  logic [31:0]        cur_adr_s;
  logic [WB_SW-1:0]   cur_sel_s;
  logic [WB_DW-1:0]   cur_dat_s;
  logic [LANE_W-1:0]  lane_s;
  logic [WB_DW-1:0]   rd_word_s;

  assign req_s   = wb.i_wb_cyc & wb.i_wb_stb;
  assign empty_s = (level_r == {(LW + 1){1'b0}});
  assign push_s  = i_inst_valid & ready_r;

  // Request attributes: live bus in IDLE (ACK_LAT=1 responds straight from accept), latched copy after
  always_comb begin
    cur_we_s  = we_r;
    cur_err_s = err_r;
    cur_adr_s = adr_r;
    cur_sel_s = sel_r;
    cur_dat_s = dat_r;
    if (state_r == ST_IDLE) begin
      cur_we_s  = wb.i_wb_we;
      cur_err_s = i_err_inject;
      cur_adr_s = wb.i_wb_adr;
      cur_sel_s = wb.i_wb_sel;
      cur_dat_s = wb.i_wb_dat;
    end else begin
      cur_we_s  = we_r;
      cur_err_s = err_r;
      cur_adr_s = adr_r;
      cur_sel_s = sel_r;
      cur_dat_s = dat_r;
    end
  end

  // Next-state logic of the transfer FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (ACK_LAT == 1) state_s = ST_RESP;
          else              state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req_s)                         state_s = ST_IDLE;
        else if (cnt_r == {CW{1'b0}})       state_s = ST_RESP;
        else                                state_s = ST_WAIT;
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Response outputs are registered on the edge that enters RESP, so they are visible during RESP
  assign enter_resp_s = (state_s == ST_RESP);
  assign pop_s        = enter_resp_s & ~cur_we_s & ~cur_err_s & ~empty_s;

  generate
    if (LANES > 1) begin : g_lane
      assign lane_s = cur_adr_s[LANE_W+1:2];
    end else begin : g_single
      assign lane_s = 1'b0;
    end
  endgenerate

  // Read word: head of queue in the addressed lane, filler everywhere else
  always_comb begin
    rd_word_s = {LANES{NOP}};
    if (!empty_s) begin
      rd_word_s[{lane_s, 5'b00000} +: 32] = mem_r[rd_ptr_r];
    end else begin
      rd_word_s = {LANES{NOP}};
    end
  end

  // Occupancy update for push, pop, both or neither
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + {{LW{1'b0}}, 1'b1};
      2'b01:   level_nxt_s = level_r - {{LW{1'b0}}, 1'b1};
      default: level_nxt_s = level_r;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Request latch and latency counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= {CW{1'b0}};
      adr_r <= 32'h0000_0000;
      sel_r <= {WB_SW{1'b0}};
      dat_r <= {WB_DW{1'b0}};
      we_r  <= 1'b0;
      err_r <= 1'b0;
    end else if (state_r == ST_IDLE && req_s) begin
      cnt_r <= CNT_LOAD;
      adr_r <= wb.i_wb_adr;
      sel_r <= wb.i_wb_sel;
      dat_r <= wb.i_wb_dat;
      we_r  <= wb.i_wb_we;
      err_r <= i_err_inject;
    end else if (state_r == ST_WAIT && cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - {{(CW - 1){1'b0}}, 1'b1};
    end
  end

  // Queue storage
  always_ff @(posedge i_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= i_inst_data;
  end

  // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r <= {LW{1'b0}};
      rd_ptr_r <= {LW{1'b0}};
      level_r  <= {(LW + 1){1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(LW - 1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(LW - 1){1'b0}}, 1'b1};
      level_r <= level_nxt_s;
      ready_r <= (level_nxt_s != FULL_LVL);
    end
  end

  // Bus termination, read data and store capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_r      <= 1'b0;
      berr_r     <= 1'b0;
      st_valid_r <= 1'b0;
      rd_dat_r   <= {LANES{NOP}};
      st_adr_r   <= 32'h0000_0000;
      st_sel_r   <= {WB_SW{1'b0}};
      st_dat_r   <= {WB_DW{1'b0}};
    end else begin
      ack_r      <= enter_resp_s & ~cur_err_s;
      berr_r     <= enter_resp_s & cur_err_s;
      st_valid_r <= enter_resp_s & cur_we_s & ~cur_err_s;
      if (enter_resp_s && !cur_we_s && !cur_err_s) rd_dat_r <= rd_word_s;
      if (enter_resp_s && cur_we_s && !cur_err_s) begin
        st_adr_r <= cur_adr_s;
        st_sel_r <= cur_sel_s;
        st_dat_r <= cur_dat_s;
      end
    end
  end

  assign o_inst_ready = ready_r;
  assign o_level      = level_r;
  assign wb.o_wb_dat  = rd_dat_r;
  assign wb.o_wb_ack  = ack_r;
  assign wb.o_wb_err  = berr_r;
  assign o_st_valid   = st_valid_r;
  assign o_st_adr     = st_adr_r;
  assign o_st_sel     = st_sel_r;
  assign o_st_dat     = st_dat_r;
endmodule
